// File: rtl/vec_mul_pkg.sv
// rtl/vec_mul_pkg.sv - shared types and constants for the vector multiply result path
package vec_mul_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    SEW8  = 3'b000,
    SEW16 = 3'b001,
    SEW32 = 3'b010
  } sew_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    OUTPUT
  } packer_state_e;

  function automatic logic sew_is_legal(input logic [2:0] sew);
    logic legal;
    case (sew)
      SEW8, SEW16, SEW32: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mul_lane_select.sv
// rtl/mul_lane_select.sv - picks the low or high SEW half of one lane-packed product beat
module mul_lane_select
  import vec_mul_pkg::*;
(
  input  logic              op_high,
  input  logic [WORD_W-1:0] product_lo,
  input  logic [WORD_W-1:0] product_hi,
  output logic [WORD_W-1:0] word
);

  assign word = op_high ? product_hi : product_lo;

endmodule

// File: rtl/mul_result_packer.sv
// rtl/mul_result_packer.sv - packs multiplier beats into one VLEN destination image for writeback
module mul_result_packer
  import vec_mul_pkg::*;
#(
  parameter int VLEN = 512
)
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [2:0]                           sew,
  input  logic                                 op_high,
  input  logic [$clog2(VLEN/WORD_W):0]         vl_beats,
  input  logic                                 mul_done,
  input  logic [WORD_W-1:0]                    mul_product_lo,
  input  logic [WORD_W-1:0]                    mul_product_hi,
  output logic                                 mul_ready,
  output logic                                 busy,
  output logic                                 wb_valid,
  input  logic                                 wb_ready,
  output logic [VLEN-1:0]                      wb_data,
  output logic [VLEN/8-1:0]                    wb_mask,
  output logic                                 err_overrun
);

  localparam int MAX_BEATS = VLEN / WORD_W;
  localparam int CNT_W     = $clog2(MAX_BEATS) + 1;

  packer_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   beats_q, beats_d;
  logic               op_high_q, op_high_d;
  logic [VLEN-1:0]    data_q, data_d;
  logic [VLEN/8-1:0]  mask_q, mask_d;
  logic               err_q, err_d;

  logic [WORD_W-1:0]  beat_word;
  logic [CNT_W-1:0]   beats_clamped;
  logic               capture;

  mul_lane_select u_lane_select (
    .op_high    (op_high_q),
    .product_lo (mul_product_lo),
    .product_hi (mul_product_hi),
    .word       (beat_word)
  );

  assign beats_clamped = (vl_beats > CNT_W'(MAX_BEATS)) ? CNT_W'(MAX_BEATS) : vl_beats;
  // The count guard keeps the counter from ever walking past the latched length.
  assign capture = (state_q == COLLECT) && mul_done && (cnt_q < beats_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    op_high_d = op_high_q;
    data_d    = data_q;
    mask_d    = mask_q;
    err_d     = err_q | (mul_done && (state_q != COLLECT));

    case (state_q)
      IDLE: begin
        if (start && sew_is_legal(sew)) begin
          op_high_d = op_high;
          beats_d   = beats_clamped;
          cnt_d     = '0;
          data_d    = '0;
          mask_d    = '0;
          state_d   = (beats_clamped == '0) ? OUTPUT : COLLECT;
        end
      end
      COLLECT: begin
        if (capture) begin
          for (int b = 0; b < MAX_BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) begin
              data_d[b*WORD_W +: WORD_W] = beat_word;
              mask_d[b*4 +: 4]           = 4'hF;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == beats_q) begin
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      beats_q   <= '0;
      op_high_q <= 1'b0;
      data_q    <= '0;
      mask_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beats_q   <= beats_d;
      op_high_q <= op_high_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
    end
  end

  assign mul_ready   = (state_q == COLLECT);
  assign busy        = (state_q != IDLE);
  assign wb_valid    = (state_q == OUTPUT);
  assign wb_data     = data_q;
  assign wb_mask     = mask_q;
  assign err_overrun = err_q;

endmodule
